// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// Column helpers assume active-low column lines.
package keypad_pkg;

  localparam int NUM_ROWS  = 4;
  localparam int NUM_COLS  = 4;
  localparam int CODE_W    = 4;
  localparam int ROW_IDX_W = $clog2(NUM_ROWS);
  localparam int COL_IDX_W = $clog2(NUM_COLS);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    EMIT,
    RELEASE
  } scan_state_t;

  function automatic logic single_low(input logic [NUM_COLS-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (!v[i]) n++;
    end
    return (n == 1);
  endfunction

  function automatic logic [COL_IDX_W-1:0] low_index(input logic [NUM_COLS-1:0] v);
    logic [COL_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (!v[i]) idx = COL_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Keypad-side and decoder-side signals of the scan controller.
// master = the controller, slave = keypad matrix plus downstream decoder.
interface keypad_scan_ctrl_if;

  logic [keypad_pkg::NUM_COLS-1:0] col;
  logic [keypad_pkg::NUM_ROWS-1:0] row;
  logic [keypad_pkg::CODE_W-1:0]   code;
  logic                            rd_enable;
  logic                            key_held;

  modport master (
    input  col,
    output row,
    output code,
    output rd_enable,
    output key_held
  );

  modport slave (
    output col,
    input  row,
    input  code,
    input  rd_enable,
    input  key_held
  );

endinterface

// File: rtl/keypad_col_sync.sv
// Two-flop synchroniser for the raw keypad columns.
// Resets to all-ones so an idle (no key) pattern is seen from the start.
module keypad_col_sync #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Row scanner, press/release debouncer and one-shot key strobe for a 4x4 keypad.
// All outputs are registered; the strobe lasts exactly one cycle per debounced press.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES   = 3,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clock,
  input  logic                reset,
  keypad_scan_ctrl_if.master  kif
);

  localparam int DW = (SETTLE_CYCLES > 1)   ? $clog2(SETTLE_CYCLES)   : 1;
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0]       DWELL_LAST = DW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0]       DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [NUM_ROWS-1:0] ROW_ONE    = NUM_ROWS'(1);

  logic [NUM_COLS-1:0] col_s;

  scan_state_t          state_q, state_d;
  logic [ROW_IDX_W-1:0] row_idx_q, row_idx_d;
  logic [DW-1:0]        dwell_q, dwell_d;
  logic [CW-1:0]        deb_q, deb_d;
  logic [ROW_IDX_W-1:0] lat_row_q, lat_row_d;
  logic [COL_IDX_W-1:0] lat_col_q, lat_col_d;
  logic [NUM_COLS-1:0]  lat_pat_q, lat_pat_d;
  logic [NUM_ROWS-1:0]  row_q, row_d;
  logic [CODE_W-1:0]    code_q, code_d;
  logic                 rd_en_q, rd_en_d;
  logic                 key_held_q, key_held_d;

  keypad_col_sync #(.W(NUM_COLS)) u_col_sync (
    .clock (clock),
    .reset (reset),
    .d     (kif.col),
    .q     (col_s)
  );

  always_comb begin
    state_d    = state_q;
    row_idx_d  = row_idx_q;
    dwell_d    = dwell_q;
    deb_d      = deb_q;
    lat_row_d  = lat_row_q;
    lat_col_d  = lat_col_q;
    lat_pat_d  = lat_pat_q;
    code_d     = code_q;
    rd_en_d    = 1'b0;
    key_held_d = key_held_q;

    case (state_q)
      SCAN: begin
        // Columns are only trusted once the row has settled through the synchroniser.
        if (dwell_q == DWELL_LAST) begin
          if (single_low(col_s)) begin
            lat_row_d = row_idx_q;
            lat_col_d = low_index(col_s);
            lat_pat_d = col_s;
            deb_d     = '0;
            state_d   = DEBOUNCE;
          end else begin
            row_idx_d = row_idx_q + ROW_IDX_W'(1);
            dwell_d   = '0;
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end

      DEBOUNCE: begin
        if (col_s == lat_pat_q) begin
          if (deb_q == DEB_LAST) begin
            state_d    = EMIT;
            code_d     = {lat_row_q, lat_col_q};
            rd_en_d    = 1'b1;
            key_held_d = 1'b1;
          end else begin
            deb_d = deb_q + CW'(1);
          end
        end else begin
          state_d   = SCAN;
          row_idx_d = row_idx_q + ROW_IDX_W'(1);
          dwell_d   = '0;
        end
      end

      EMIT: begin
        deb_d   = '0;
        state_d = RELEASE;
      end

      RELEASE: begin
        // Any low column (the same key or another one) restarts the release count.
        if (col_s == '1) begin
          if (deb_q == DEB_LAST) begin
            key_held_d = 1'b0;
            state_d    = SCAN;
            row_idx_d  = row_idx_q + ROW_IDX_W'(1);
            dwell_d    = '0;
          end else begin
            deb_d = deb_q + CW'(1);
          end
        end else begin
          deb_d = '0;
        end
      end

      default: state_d = SCAN;
    endcase

    row_d = ~(ROW_ONE << row_idx_d);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= SCAN;
      row_idx_q  <= '0;
      dwell_q    <= '0;
      deb_q      <= '0;
      lat_row_q  <= '0;
      lat_col_q  <= '0;
      lat_pat_q  <= '1;
      row_q      <= ~ROW_ONE;
      code_q     <= '0;
      rd_en_q    <= 1'b0;
      key_held_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_idx_q  <= row_idx_d;
      dwell_q    <= dwell_d;
      deb_q      <= deb_d;
      lat_row_q  <= lat_row_d;
      lat_col_q  <= lat_col_d;
      lat_pat_q  <= lat_pat_d;
      row_q      <= row_d;
      code_q     <= code_d;
      rd_en_q    <= rd_en_d;
      key_held_q <= key_held_d;
    end
  end

  assign kif.row       = row_q;
  assign kif.code      = code_q;
  assign kif.rd_enable = rd_en_q;
  assign kif.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Scoreboarded bench for keypad_scan_ctrl: a small keypad matrix model drives the
// columns from the row outputs, expected codes are queued per press and popped on strobes.
module tb_keypad_scan_ctrl;

  localparam int SETTLE   = 3;
  localparam int DEBOUNCE = 4;
  localparam int LAT      = (SETTLE - 1) + DEBOUNCE + 1;

  logic clock;
  logic reset;

  keypad_scan_ctrl_if kif ();

  keypad_scan_ctrl #(.SETTLE_CYCLES(SETTLE), .DEBOUNCE_CYCLES(DEBOUNCE)) dut (
    .clock (clock),
    .reset (reset),
    .kif   (kif)
  );

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;
  logic [3:0] exp_q[$];
  logic [3:0] mon_exp;
  logic       prev_rd = 1'b0;

  // Keypad matrix model: a pressed key pulls its column low while its row is driven.
  logic       k1_on = 1'b0, k2_on = 1'b0;
  logic [1:0] k1_r = '0, k1_c = '0, k2_r = '0, k2_c = '0;
  logic       direct_mode = 1'b0;
  logic [3:0] col_drv = 4'b1111;
  logic [3:0] col_model;

  always_comb begin
    col_model = 4'b1111;
    if (k1_on && !kif.row[k1_r]) col_model[k1_c] = 1'b0;
    if (k2_on && !kif.row[k2_r]) col_model[k2_c] = 1'b0;
  end

  assign kif.col = direct_mode ? col_drv : col_model;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (kif.rd_enable) begin
      pulses++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe code=%h expected no strobe", kif.code);
      end else begin
        mon_exp = exp_q.pop_front();
        if (kif.code !== mon_exp) begin
          failures++;
          $display("FAIL strobe_code got=%h exp=%h", kif.code, mon_exp);
        end
      end
      if (prev_rd) begin
        failures++;
        $display("FAIL double_strobe rd_enable high on consecutive cycles, exp single cycle");
      end
    end
    prev_rd = kif.rd_enable;
  end

  function automatic logic [3:0] rowpat(input int r);
    logic [3:0] v;
    v = 4'b1111;
    v[r] = 1'b0;
    return v;
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick;
    tick;
    checks += 4;
    if (kif.row !== 4'b1110) begin failures++; $display("FAIL reset_row got=%b exp=1110", kif.row); end
    if (kif.code !== 4'h0) begin failures++; $display("FAIL reset_code got=%h exp=0", kif.code); end
    if (kif.rd_enable !== 1'b0) begin failures++; $display("FAIL reset_rd got=%b exp=0", kif.rd_enable); end
    if (kif.key_held !== 1'b0) begin failures++; $display("FAIL reset_held got=%b exp=0", kif.key_held); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_idle;
    logic [3:0] exp_row;
    #1;
    for (int i = 0; i < 40; i++) begin
      exp_row = rowpat((i / SETTLE) % 4);
      checks++;
      if (kif.row !== exp_row) begin
        failures++;
        $display("FAIL idle_row cycle=%0d got=%b exp=%b", i, kif.row, exp_row);
      end
      tick;
    end
  endtask

  task automatic test_key(input logic [1:0] r, input logic [1:0] c, input int hold, input bit second);
    int n;
    int p0;
    logic [3:0] exp_code;
    logic [1:0] nr;
    exp_code = {r, c};
    nr = r + 2'd1;
    n = 0;
    while (kif.row === rowpat(r) && n < 40) begin tick; n++; end
    k1_r = r; k1_c = c; k1_on = 1'b1;
    exp_q.push_back(exp_code);
    p0 = pulses;
    n = 0;
    while (kif.row !== rowpat(r) && n < 40) begin tick; n++; end
    checks++;
    if (n >= 40) begin failures++; $display("FAIL key_row_wait timeout waiting for row=%b", rowpat(r)); end
    n = 0;
    while (kif.rd_enable !== 1'b1 && n < 50) begin tick; n++; end
    checks += 2;
    if (n !== LAT) begin failures++; $display("FAIL press_latency got=%0d exp=%0d", n, LAT); end
    if (kif.key_held !== 1'b1) begin failures++; $display("FAIL held_at_strobe got=%b exp=1", kif.key_held); end
    for (int i = 0; i < hold; i++) begin
      tick;
      if (second && i == hold / 4) begin k2_r = r; k2_c = c + 2'd1; k2_on = 1'b1; end
      if (second && i == hold / 2) k2_on = 1'b0;
    end
    checks++;
    if (kif.key_held !== 1'b1) begin failures++; $display("FAIL held_during_hold got=%b exp=1", kif.key_held); end
    k1_on = 1'b0;
    repeat (5) tick;
    checks++;
    if (kif.key_held !== 1'b1) begin failures++; $display("FAIL held_before_release_done got=%b exp=1", kif.key_held); end
    tick;
    checks += 4;
    if (kif.key_held !== 1'b0) begin failures++; $display("FAIL held_after_release got=%b exp=0", kif.key_held); end
    if (kif.row !== rowpat(nr)) begin failures++; $display("FAIL row_after_release got=%b exp=%b", kif.row, rowpat(nr)); end
    if (kif.code !== exp_code) begin failures++; $display("FAIL code_hold got=%h exp=%h", kif.code, exp_code); end
    if (pulses - p0 !== 1) begin failures++; $display("FAIL pulse_count got=%0d exp=1", pulses - p0); end
  endtask

  task automatic test_bounce;
    int n;
    int p0;
    bit saw_next;
    n = 0;
    while (kif.row === 4'b1011 && n < 40) begin tick; n++; end
    k1_r = 2'd2; k1_c = 2'd1; k1_on = 1'b1;
    p0 = pulses;
    n = 0;
    while (kif.row !== 4'b1011 && n < 40) begin tick; n++; end
    repeat (3) tick;
    saw_next = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (i % 2 == 0) k1_on = ~k1_on;
      tick;
      if (kif.row === 4'b0111) saw_next = 1'b1;
    end
    k1_on = 1'b0;
    repeat (10) tick;
    checks += 2;
    if (pulses !== p0) begin failures++; $display("FAIL bounce_pulses got=%0d exp=0", pulses - p0); end
    if (!saw_next) begin failures++; $display("FAIL bounce_row_advance got=0 exp=1 (row 0111 never seen)"); end
    test_key(2'd2, 2'd1, 10, 1'b0);
  endtask

  task automatic test_multi;
    int p0;
    logic [3:0] seen;
    p0 = pulses;
    seen = 4'b0000;
    direct_mode = 1'b1;
    col_drv = 4'b1100;
    for (int i = 0; i < 30; i++) begin
      tick;
      for (int r = 0; r < 4; r++) if (kif.row === rowpat(r)) seen[r] = 1'b1;
    end
    direct_mode = 1'b0;
    col_drv = 4'b1111;
    repeat (4) tick;
    checks += 2;
    if (pulses !== p0) begin failures++; $display("FAIL multi_pulses got=%0d exp=0", pulses - p0); end
    if (seen !== 4'b1111) begin failures++; $display("FAIL multi_rows_seen got=%b exp=1111", seen); end
  endtask

  task automatic test_reset_mid;
    int n;
    int p0;
    // Reset while debouncing a press of row 1 / col 2.
    n = 0;
    while (kif.row === 4'b1101 && n < 40) begin tick; n++; end
    k1_r = 2'd1; k1_c = 2'd2; k1_on = 1'b1;
    n = 0;
    while (kif.row !== 4'b1101 && n < 40) begin tick; n++; end
    repeat (4) tick;
    #2 reset = 1'b1;
    #1;
    checks += 4;
    if (kif.row !== 4'b1110) begin failures++; $display("FAIL rst_deb_row got=%b exp=1110", kif.row); end
    if (kif.rd_enable !== 1'b0) begin failures++; $display("FAIL rst_deb_rd got=%b exp=0", kif.rd_enable); end
    if (kif.key_held !== 1'b0) begin failures++; $display("FAIL rst_deb_held got=%b exp=0", kif.key_held); end
    if (kif.code !== 4'h0) begin failures++; $display("FAIL rst_deb_code got=%h exp=0", kif.code); end
    k1_on = 1'b0;
    repeat (2) tick;
    @(negedge clock);
    reset = 1'b0;
    p0 = pulses;
    repeat (30) tick;
    checks++;
    if (pulses !== p0) begin failures++; $display("FAIL rst_deb_no_strobe got=%0d exp=0", pulses - p0); end

    // Reset in the EMIT cycle, before the strobe is ever sampled at the falling edge.
    k1_on = 1'b1;
    n = 0;
    while (kif.rd_enable !== 1'b1 && n < 60) begin tick; n++; end
    checks++;
    if (n >= 60) begin failures++; $display("FAIL rst_emit_wait timeout waiting for rd_enable"); end
    #1 reset = 1'b1;
    #1;
    checks += 4;
    if (kif.row !== 4'b1110) begin failures++; $display("FAIL rst_emit_row got=%b exp=1110", kif.row); end
    if (kif.rd_enable !== 1'b0) begin failures++; $display("FAIL rst_emit_rd got=%b exp=0", kif.rd_enable); end
    if (kif.key_held !== 1'b0) begin failures++; $display("FAIL rst_emit_held got=%b exp=0", kif.key_held); end
    if (kif.code !== 4'h0) begin failures++; $display("FAIL rst_emit_code got=%h exp=0", kif.code); end
    k1_on = 1'b0;
    repeat (3) tick;
    @(negedge clock);
    reset = 1'b0;
    p0 = pulses;
    repeat (30) tick;
    checks++;
    if (pulses !== p0) begin failures++; $display("FAIL rst_emit_no_strobe got=%0d exp=0", pulses - p0); end
  endtask

  initial begin
    reset = 1'b1;
    test_reset;
    test_idle;
    test_key(2'd2, 2'd1, 10, 1'b0);
    test_key(2'd3, 2'd3, 100, 1'b1);
    test_bounce;
    test_multi;
    test_key(2'd0, 2'd2, 6, 1'b0);
    test_reset_mid;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_strobes got=%0d pending exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Sequencer for the keypad front end of the scanner/encoder.
- Drives the 4x4 keypad rows one at a time and synchronises the column inputs.
- Debounces a single key press and issues a one-cycle rd_enable strobe with a 4-bit key code to the downstream BCD decoder, which registers code on the same clock edge.
- Suppresses repeats until the key is released and debounced.

Parameters:
- SETTLE_CYCLES, 3: cycles each row is driven before columns are sampled; must be >= 3 to cover the synchroniser latency.
- DEBOUNCE_CYCLES, 4: consecutive stable samples required for both press and release; must be >= 2.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- col  input  4  raw keypad columns, active-low, asynchronous to clock.
- row  output  4  row drive, one-hot active-low; bit r=0 selects row r.
- code  output  4  key code = row*4 + col index; holds the last emitted value.
- rd_enable  output  1  one-cycle strobe; code is valid while it is high.
- key_held  output  1  high from EMIT until release debounce completes.

Behaviour:
- Reset values (asynchronous): row=4'b1110, code=0, rd_enable=0, key_held=0. State=SCAN, row index=0, all counters=0, synchroniser flops=4'b1111.
- Synchroniser: col passes through 2 flops to give col_s, 2-cycle latency.
- "Single key" means col_s has exactly one bit low; the column index c is that bit position.
- SCAN:
  - Drive the current row; the dwell counter counts 0..SETTLE_CYCLES-1.
  - At dwell=SETTLE_CYCLES-1, sample col_s.
  - Single key: latch r, c and the col_s pattern, clear the debounce counter, go to DEBOUNCE.
  - Otherwise (none or multiple low): advance row (3 wraps to 0), clear dwell, stay in SCAN.
  - Full scan period with no key is 4*SETTLE_CYCLES cycles.
- DEBOUNCE:
  - Hold the row.
  - Each cycle col_s equals the latched pattern: increment the counter.
  - When the counter reaches DEBOUNCE_CYCLES-1: go to EMIT.
  - Any mismatch: go to SCAN at the next row with dwell cleared; no strobe.
- EMIT (exactly 1 cycle):
  - The registered outputs take effect on entry: code={r[1:0],c[1:0]}, rd_enable=1, key_held=1.
  - Next state is RELEASE; rd_enable returns to 0 on the following edge.
- RELEASE:
  - Hold the row; the counter counts consecutive cycles with col_s=4'b1111.
  - Any low bit clears the counter.
  - When the counter reaches DEBOUNCE_CYCLES-1: key_held=0, go to SCAN at the next row.
  - A second key pressed while the first is held produces no strobe.
- Press latency: from the first sampling cycle with a stable key to rd_enable high is DEBOUNCE_CYCLES+1 cycles.
- code is stable in all states except on the EMIT edge.
- rd_enable is never high for two consecutive cycles.
- Reset asserted mid-operation: all outputs return to reset values immediately, with no partial strobe. After reset deasserts, scanning restarts from row 0.
- Counter widths: $clog2 of the respective parameter, minimum 1 bit. Counters saturate and never wrap.

Decomposition:
- Package keypad_pkg holds:
  - NUM_ROWS=4 and NUM_COLS=4.
  - Enum scan_state_t {SCAN, DEBOUNCE, EMIT, RELEASE}.
  - The code width constant CODE_W=4.
- One sub-module, keypad_col_sync: 4-bit, 2-flop synchroniser with asynchronous reset to all-ones.
- The FSM and counters live in keypad_scan_ctrl.

Test Plan:
- Idle: col=4'b1111 for 40 cycles -> row cycles 1110,1101,1011,0111, each held 3 cycles; rd_enable stays 0.
- Key row 2 / col 1: hold col=4'b1101 while row=4'b1011 -> exactly one rd_enable pulse with code=4'b1001 (decoder BCD=8'h09). key_held=1 until 4 cycles after col returns to 1111.
- Key row 3 / col 3: pulse with code=4'b1111 (BCD=8'h15). Keep the key held 100 cycles -> no second pulse; after release, scanning resumes at row 0.
- Bounce: col toggles 1101/1111 every 2 cycles during DEBOUNCE -> no rd_enable; row advances. After bounce stops, a clean press gives a single pulse.
- Multiple keys: col=4'b1100 on row 0 -> ignored; no pulse; scanning continues.
- Reset mid-debounce and mid-EMIT: assert reset asynchronously between edges -> row=1110, rd_enable=0 and key_held=0 immediately. code=0; no strobe after release.
